multi_arg_decoder: RTL and testbench
====================================

MULTI_ARG_DECODER -- requirements
Module: multi_arg_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction/argument word width.
REQ-002 SHALL have parameter MAX_ARGS, default 3, meaning maximum argument words per instruction (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning decoded-uop queue entries (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1, meaning clock; reset n_rst, asynchronous, active-low.
REQ-005 SHALL have port n_rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have in_valid/in_ready (input/output, 1 each), meaning word handshake; a word is accepted when both are high at a clk rising edge.
REQ-007 SHALL have in_data, input, DATA_W, meaning opcode or argument word.
REQ-008 SHALL have lock, input, 1, meaning stall: hold all state, no accept.
REQ-009 SHALL have flush, input, 1, meaning synchronous abort of the partial instruction and the queue.
REQ-010 SHALL have uop_valid/uop_ready (output/input, 1 each), meaning uop handshake.
REQ-011 SHALL have the following uop outputs: uop_opcode (DATA_W); uop_args (MAX_ARGS*DATA_W; arg0 in the LSBs; unused slots 0); uop_nargs ($clog2(MAX_ARGS+1)); uop_wb (1, memory write-back required); uop_illegal (1).
REQ-012 SHALL have pc_load (output, 1) and pc_target (output, DATA_W), meaning one-cycle PC redirect.
REQ-013 SHALL have busy, output, 1, meaning a partial instruction is held or the queue is non-empty.

Function
REQ-014 Opcode table (package) SHALL be: NOP=0x0000 (0 args), LOAD=0x0001 (2), MOV_RR=0x0002 (2), MOV_RA=0x0003 (2, wb=1), ADD=0x0004 (2), JMP=0x0005 (1), ADD3=0x0006 (3); opcode compare SHALL use the full DATA_W.
REQ-015 An unlisted opcode SHALL be treated as 0 args with uop_illegal=1.
REQ-016 The FSM SHALL have two states, OPCODE and ARGS; reset state is OPCODE.
REQ-017 In OPCODE, an accepted word SHALL be latched as the opcode; a 0-arg op SHALL push a uop in the same edge and stay in OPCODE; otherwise the FSM SHALL go to ARGS with arg counter = 0.
REQ-018 In ARGS, each accepted word SHALL be stored in slot [counter]; on the last argument the uop SHALL be pushed in the same edge and the FSM SHALL return to OPCODE.
REQ-019 in_ready SHALL equal !lock && !flush && (queue count < FIFO_DEPTH); no combinational path from uop_ready to in_ready is allowed.
REQ-020 Latency: with an empty queue, uop_valid SHALL rise on the cycle after the completing word is accepted.
REQ-021 The queue SHALL be first-in first-out; uop outputs SHALL be driven from the registered head entry and SHALL stay stable while uop_valid && !uop_ready.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged; a pop with uop_ready while empty SHALL be ignored.
REQ-023 When the final JMP argument is accepted, pc_load SHALL be 1 for exactly the next cycle with pc_target = that argument; otherwise pc_load=0 and pc_target holds its last value.
REQ-024 While lock=1, state, counter, queue contents and pc_load (forced 0) SHALL hold, but queue pops SHALL still occur.
REQ-025 flush=1 SHALL, at the next edge, set the FSM to OPCODE, clear the counter, empty the queue, and suppress any push or pc_load; flush has priority over all events.
REQ-026 busy SHALL equal (state==ARGS) || (count!=0).

Reset
REQ-027 On n_rst low, the block SHALL asynchronously reset to: state OPCODE, counter 0, queue empty, uop_valid 0, all uop fields 0, pc_load 0, pc_target 0, in_ready 0 (in_ready is then driven per REQ-019 after release).
REQ-028 Reset asserted mid-instruction SHALL discard all partial and queued content.

Structure
REQ-029 Opcode constants, the arg-count/wb lookup function and the state enum SHALL reside in shared package macpu_decode_pkg.
REQ-030 The queue SHALL be a separate sub-module, uop_fifo (parametrised width/depth, count output, sync clear).

Verification
REQ-031 Send ADD3 0x0006, 0x0001, 0x0002, 0x0003 back-to-back -> one uop: nargs=3, args={0x3,0x2,0x1}, uop_valid one cycle after the 4th accept.
REQ-032 Send JMP 0x0005, 0x1234 -> pc_load=1 for one cycle, pc_target=0x1234, uop nargs=1.
REQ-033 Send 0xBEEF -> uop_illegal=1, nargs=0, FSM stays in OPCODE.
REQ-034 Hold uop_ready=0 and send 5 NOPs with FIFO_DEPTH=4 -> in_ready drops after 4 accepts; raising uop_ready drains them in order and the 5th is accepted.
REQ-035 Send LOAD plus one argument, then assert flush -> busy=0 next cycle, no uop emitted, the next word is decoded as an opcode.
REQ-036 Assert lock mid-MOV_RA -> in_ready=0 and state held; after release the argument completes and the uop shows wb=1.

Source files
------------

// File: rtl/macpu_decode_pkg.sv
// Shared decode definitions for the multi-word instruction decoder:
// opcode constants, per-opcode argument/write-back lookup, FSM states.
package macpu_decode_pkg;

    localparam logic [63:0] OP_NOP    = 64'h0000;
    localparam logic [63:0] OP_LOAD   = 64'h0001;
    localparam logic [63:0] OP_MOV_RR = 64'h0002;
    localparam logic [63:0] OP_MOV_RA = 64'h0003;
    localparam logic [63:0] OP_ADD    = 64'h0004;
    localparam logic [63:0] OP_JMP    = 64'h0005;
    localparam logic [63:0] OP_ADD3   = 64'h0006;

    typedef enum logic {
        ST_OPCODE = 1'b0,
        ST_ARGS   = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic [7:0] nargs;
        logic       wb;
        logic       illegal;
    } op_info_t;

    // Opcodes are zero-extended to 64 bits so the compare covers the full word
    function automatic op_info_t op_lookup(input logic [63:0] op);
        op_info_t r;
        r = '{nargs: 8'd0, wb: 1'b0, illegal: 1'b0};
        case (op)
            OP_NOP:    r.nargs = 8'd0;
            OP_LOAD:   r.nargs = 8'd2;
            OP_MOV_RR: r.nargs = 8'd2;
            OP_MOV_RA: begin
                r.nargs = 8'd2;
                r.wb    = 1'b1;
            end
            OP_ADD:    r.nargs = 8'd2;
            OP_JMP:    r.nargs = 8'd1;
            OP_ADD3:   r.nargs = 8'd3;
            default:   r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// Decoded-uop queue: registered storage, head read from the array,
// synchronous clear that takes priority over push/pop.
module uop_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
    assign dout    = mem[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_q] <= din;
                wr_q      <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop) cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/multi_arg_decoder.sv
// Assembles opcode + argument words into uops, queues them, and
// raises a one-cycle PC redirect when a JMP completes.
module multi_arg_decoder
    import macpu_decode_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_ARGS   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          lock,
    input  logic                          flush,
    output logic                          uop_valid,
    input  logic                          uop_ready,
    output logic [DATA_W-1:0]             uop_opcode,
    output logic [MAX_ARGS*DATA_W-1:0]    uop_args,
    output logic [$clog2(MAX_ARGS+1)-1:0] uop_nargs,
    output logic                          uop_wb,
    output logic                          uop_illegal,
    output logic                          pc_load,
    output logic [DATA_W-1:0]             pc_target,
    output logic                          busy
);

    localparam int NW = $clog2(MAX_ARGS+1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = DATA_W + MAX_ARGS*DATA_W + NW + 2;

    dec_state_e           state_q, state_n;
    logic [NW-1:0]        cnt_q, cnt_n;
    logic [DATA_W-1:0]    op_q, op_n;
    logic [NW-1:0]        nargs_q, nargs_n;
    logic                 wb_q, wb_n;
    logic [DATA_W-1:0]    args_q [MAX_ARGS];
    logic [DATA_W-1:0]    args_n [MAX_ARGS];
    logic [MAX_ARGS*DATA_W-1:0] args_flat;
    logic                 pc_load_q, pc_load_n;
    logic [DATA_W-1:0]    pc_tgt_q, pc_tgt_n;
    logic                 rdy_en_q;
    logic                 push, ill, accept;
    logic [UW-1:0]        push_data, head;
    logic [AW:0]          fcount;
    op_info_t             info;

    assign info     = op_lookup(64'(in_data));
    assign in_ready = rdy_en_q && !lock && !flush &&
                      (fcount < (AW+1)'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        op_n      = op_q;
        nargs_n   = nargs_q;
        wb_n      = wb_q;
        args_n    = args_q;
        push      = 1'b0;
        ill       = 1'b0;
        pc_load_n = 1'b0;
        pc_tgt_n  = pc_tgt_q;
        if (flush) begin
            state_n = ST_OPCODE;
            cnt_n   = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_OPCODE: begin
                    op_n    = in_data;
                    nargs_n = info.nargs[NW-1:0];
                    wb_n    = info.wb;
                    cnt_n   = '0;
                    for (int i = 0; i < MAX_ARGS; i++) args_n[i] = '0;
                    if (info.nargs == 8'd0) begin
                        push = 1'b1;
                        ill  = info.illegal;
                    end else begin
                        state_n = ST_ARGS;
                    end
                end
                ST_ARGS: begin
                    for (int i = 0; i < MAX_ARGS; i++)
                        if (cnt_q == NW'(i)) args_n[i] = in_data;
                    if (cnt_q == nargs_q - NW'(1)) begin
                        push    = 1'b1;
                        state_n = ST_OPCODE;
                        cnt_n   = '0;
                        if (64'(op_q) == OP_JMP) begin
                            pc_load_n = 1'b1;
                            pc_tgt_n  = in_data;
                        end
                    end else begin
                        cnt_n = cnt_q + NW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        args_flat = '0;
        for (int i = 0; i < MAX_ARGS; i++)
            args_flat[i*DATA_W +: DATA_W] = args_n[i];
    end

    assign push_data = {op_n, args_flat, nargs_n, wb_n, ill};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_OPCODE;
            cnt_q     <= '0;
            op_q      <= '0;
            nargs_q   <= '0;
            wb_q      <= 1'b0;
            pc_load_q <= 1'b0;
            pc_tgt_q  <= '0;
            rdy_en_q  <= 1'b0;
            for (int i = 0; i < MAX_ARGS; i++) args_q[i] <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            op_q      <= op_n;
            nargs_q   <= nargs_n;
            wb_q      <= wb_n;
            pc_load_q <= pc_load_n;
            pc_tgt_q  <= pc_tgt_n;
            rdy_en_q  <= 1'b1;
            args_q    <= args_n;
        end
    end

    uop_fifo #(
        .W     (UW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (flush),
        .push  (push),
        .din   (push_data),
        .pop   (uop_ready),
        .dout  (head),
        .count (fcount)
    );

    assign {uop_opcode, uop_args, uop_nargs, uop_wb, uop_illegal} = head;
    assign uop_valid = (fcount != '0);
    assign busy      = (state_q == ST_ARGS) || (fcount != '0);
    // lock masks the redirect pulse rather than delaying it
    assign pc_load   = pc_load_q && !lock;
    assign pc_target = pc_tgt_q;

endmodule

// File: tb/tb_multi_arg_decoder.sv
// Directed scoreboard bench for multi_arg_decoder.
// Expected uops are queued at drive time and checked at each handshake.
module tb_multi_arg_decoder;

    typedef struct packed {
        logic [15:0] op;
        logic [47:0] args;
        logic [1:0]  nargs;
        logic        wb;
        logic        ill;
    } uop_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        lock = 1'b0;
    logic        flush = 1'b0;
    logic        uop_valid;
    logic        uop_ready = 1'b0;
    logic [15:0] uop_opcode;
    logic [47:0] uop_args;
    logic [1:0]  uop_nargs;
    logic        uop_wb;
    logic        uop_illegal;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        busy;

    uop_t exp_q[$];
    uop_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_arg_decoder #(
        .DATA_W     (16),
        .MAX_ARGS   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lock        (lock),
        .flush       (flush),
        .uop_valid   (uop_valid),
        .uop_ready   (uop_ready),
        .uop_opcode  (uop_opcode),
        .uop_args    (uop_args),
        .uop_nargs   (uop_nargs),
        .uop_wb      (uop_wb),
        .uop_illegal (uop_illegal),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] op, input logic [47:0] args,
                            input logic [1:0] nargs, input logic wb,
                            input logic ill);
        exp_q.push_back('{op: op, args: args, nargs: nargs, wb: wb, ill: ill});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 64'(n), 64'(0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < 60), 64'(1));
    endtask

    always begin
        @(negedge clk);
        #2;
        if (n_rst && uop_valid && uop_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_uop", 64'(uop_opcode), 64'hDEAD_0000_0000);
            end else begin
                mon_e = exp_q.pop_front();
                check("uop_opcode", 64'(uop_opcode), 64'(mon_e.op));
                check("uop_args", 64'(uop_args), 64'(mon_e.args));
                check("uop_nargs", 64'(uop_nargs), 64'(mon_e.nargs));
                check("uop_wb", 64'(uop_wb), 64'(mon_e.wb));
                check("uop_illegal", 64'(uop_illegal), 64'(mon_e.ill));
            end
        end
    end

    initial begin
        #3;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_uop_valid", 64'(uop_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pc_load", 64'(pc_load), 64'(0));
        check("rst_pc_target", 64'(pc_target), 64'(0));
        check("rst_uop_fields",
              64'({uop_opcode, uop_nargs, uop_wb, uop_illegal}), 64'(0));
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'(1));
        uop_ready = 1'b1;

        // ADD3 with back-to-back arguments
        push_exp(16'h0006, 48'h0003_0002_0001, 2'd3, 1'b0, 1'b0);
        send(16'h0006);
        send(16'h0001);
        send(16'h0002);
        check("add3_not_yet", 64'(uop_valid), 64'(0));
        check("add3_busy", 64'(busy), 64'(1));
        send(16'h0003);
        check("add3_latency", 64'(uop_valid), 64'(1));
        wait_idle();

        // JMP redirect pulse
        push_exp(16'h0005, 48'h0000_0000_1234, 2'd1, 1'b0, 1'b0);
        send(16'h0005);
        check("jmp_no_early_load", 64'(pc_load), 64'(0));
        send(16'h1234);
        check("jmp_pc_load", 64'(pc_load), 64'(1));
        check("jmp_pc_target", 64'(pc_target), 64'h1234);
        @(negedge clk);
        check("jmp_pc_load_once", 64'(pc_load), 64'(0));
        check("jmp_target_hold", 64'(pc_target), 64'h1234);
        wait_idle();

        // Illegal opcode stays in OPCODE
        push_exp(16'hBEEF, 48'h0, 2'd0, 1'b0, 1'b1);
        send(16'hBEEF);
        check("illegal_queued", 64'(busy), 64'(1));
        @(negedge clk);
        check("illegal_opcode_state", 64'(busy), 64'(0));

        // Fill the queue with NOPs while the consumer stalls
        uop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(16'h0000, 48'h0, 2'd0, 1'b0, 1'b0);
            send(16'h0000);
        end
        in_valid = 1'b1;
        in_data  = 16'h0000;
        #1;
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_uop_valid", 64'(uop_valid), 64'(1));
        in_valid = 1'b0;
        push_exp(16'h0000, 48'h0, 2'd0, 1'b0, 1'b0);
        uop_ready = 1'b1;
        send(16'h0000);
        wait_idle();

        // Flush a partial LOAD
        send(16'h0001);
        send(16'hAAAA);
        check("load_partial_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_uop_valid", 64'(uop_valid), 64'(0));
        push_exp(16'h0000, 48'h0, 2'd0, 1'b0, 1'b0);
        send(16'h0000);
        wait_idle();

        // Lock in the middle of MOV_RA
        push_exp(16'h0003, 48'h0000_0022_0011, 2'd2, 1'b1, 1'b0);
        send(16'h0003);
        send(16'h0011);
        lock     = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0022;
        #1;
        check("lock_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(negedge clk);
        check("lock_state_held", 64'(busy), 64'(1));
        check("lock_no_uop", 64'(uop_valid), 64'(0));
        lock = 1'b0;
        send(16'h0022);
        wait_idle();

        // Reset mid-instruction with a queued uop
        uop_ready = 1'b0;
        send(16'h0000);
        send(16'h0004);
        send(16'h0007);
        check("pre_rst_busy", 64'(busy), 64'(1));
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_uop_valid", 64'(uop_valid), 64'(0));
        check("mid_rst_pc_target", 64'(pc_target), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        uop_ready = 1'b1;
        push_exp(16'h0004, 48'h0000_0008_0007, 2'd2, 1'b0, 1'b0);
        send(16'h0004);
        send(16'h0007);
        send(16'h0008);
        wait_idle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
